toggle_stream_decoder: RTL and testbench
========================================

Name: toggle_stream_decoder

Overview:
Receive-side counterpart of the toggle (T) flip-flop line driver. A toggle-encoded serial line carries each bit as a transition: a transition means 1, no transition means 0. This block recovers the bit stream and removes stuffed bits. It assembles the bits LSB-first into WIDTH-bit words and presents each word on a single-entry valid/ready output register, with error and overflow flags.

Parameters:
WIDTH, 8, bits per output word; legal range 1..16.
STUFF_LEN, 6, count of consecutive decoded 1s after which one stuffed 0 follows; 0 disables unstuffing; legal range 0..15.

Ports:
Clock  input  1  rising-edge clock for all state.
Clear  input  1  synchronous, active-high reset; has priority over every other input.
In_Valid  input  1  qualifies Line and Sync for the current cycle; when it is low, no state changes except the output handshake.
Line  input  1  toggle-encoded line sample.
Sync  input  1  start-of-frame marker; acted on only when In_Valid is high.
Data_Out  output  WIDTH  assembled word.
Out_Valid  output  1  Data_Out holds an unconsumed word.
Out_Ready  input  1  consumer accepts the word when Out_Valid and Out_Ready are both high.
Overflow  output  1  one-cycle pulse: a completed word was dropped.
Stuff_Error  output  1  one-cycle pulse: a stuffing violation aborted the frame.
Busy  output  1  high while in state RECV.

Behaviour:
- Reset (Clear=1 at a rising edge):
  - State returns to HUNT.
  - Prev_Line, shift register, bit count, ones count, Data_Out, Out_Valid, Overflow and Stuff_Error all become 0.
- States:
  - HUNT: ignores samples unless Sync is present.
  - RECV: decodes bits.
- Sync handling:
  - In_Valid=1 and Sync=1, in either state: go to RECV, set Prev_Line=Line, clear shift register, bit count and ones count.
  - No bit is produced on the Sync sample.
  - A Sync in RECV mid-word discards the partial word; the output register is untouched.
- Decoding, in RECV with In_Valid=1 and Sync=0:
  - Decoded bit b = Line XOR Prev_Line; then Prev_Line <= Line.
- Unstuffing (STUFF_LEN>0):
  - Each decoded 1 increments the ones count; each decoded 0 clears it.
  - When the ones count equals STUFF_LEN, the next decoded bit is the stuff bit:
    - If it is 0: discard it, clear the ones count, do not shift it in.
    - If it is 1: Stuff_Error pulses high the next cycle, the partial word is discarded, and the state goes to HUNT.
- Assembly:
  - Non-stuff bits shift in LSB-first; the bit count increments.
  - When the bit count reaches WIDTH, the word completes and the bit count returns to 0.
  - The ones count carries across word boundaries within a frame.
- Latency: for the sample that completes a word at edge N, Data_Out and Out_Valid update at edge N (visible in cycle N+1).
- Output handshake:
  - Out_Valid falls on the edge after a cycle with Out_Valid=1 and Out_Ready=1, unless a new word is loaded at that same edge.
  - Completion with Out_Valid=0, or with Out_Valid=1 and Out_Ready=1 in the same cycle: load the new word, Out_Valid=1, no overflow.
  - Completion with Out_Valid=1 and Out_Ready=0: the new word is dropped, Data_Out holds its value, Overflow pulses one cycle.
- Handshake independence: the handshake operates in every state and regardless of In_Valid. Data_Out is stable while Out_Valid=1 and Out_Ready=0.
- Pulse width: Overflow and Stuff_Error are exactly one cycle wide per event.

Test Plan:
- Basic word: STUFF_LEN=6. Sync with Line=0, then Line=1,1,0,0,0,1,1,0 on consecutive In_Valid cycles -> Data_Out=0xA5, Out_Valid=1 in the cycle after the 8th sample, Busy=1 throughout.
- Unstuffing: Sync with Line=0, then Line=1,0,1,0,1,0,0,1,0 -> seventh sample is discarded as a stuff bit; Data_Out=0xFF after the 9th sample; Stuff_Error stays 0.
- Stuff violation: Sync with Line=0, then Line=1,0,1,0,1,0,1 -> Stuff_Error pulses for 1 cycle after the 7th sample, Busy=0, Out_Valid stays 0; later samples are ignored until the next Sync.
- Overflow and back-pressure:
  - Out_Ready=0; send 0xA5 then a second word 0x00 (Line held constant) -> Overflow pulses once on the second completion; Data_Out stays 0xA5.
  - Raise Out_Ready for one cycle -> Out_Valid falls.
  - Repeat with Out_Ready=1 on the completion cycle -> 0x00 is loaded, no Overflow.
- Mid-frame events:
  - Clear after 4 samples -> all outputs 0, Busy=0.
  - A new Sync after 4 samples of the next frame, then a full 0xA5 sequence -> exactly one word 0xA5.
  - In_Valid=0 gaps inserted between samples -> same result as without gaps.

Source files
------------

// File: rtl/toggle_stream_decoder.sv
// rtl/toggle_stream_decoder.sv - toggle-line bit recovery, unstuffing and word assembly
// Recovers bits from transitions, drops stuffed zeros, assembles LSB-first words into a one-entry output register.
module toggle_stream_decoder #(
    parameter int WIDTH     = 8,
    parameter int STUFF_LEN = 6
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             in_valid_i,
    input  logic             line_i,
    input  logic             sync_i,
    output logic [WIDTH-1:0] data_out_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             overflow_o,
    output logic             stuff_error_o,
    output logic             busy_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        HUNT,
        RECV
    } state_t;

    state_t           state_q, state_d;
    logic             prev_q, prev_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [3:0]       ones_q, ones_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             serr_q, serr_d;

    logic             bit_dec;
    logic             stuff_slot;
    logic [WIDTH-1:0] shifted;

    // A shift-then-insert form keeps WIDTH=1 legal without a zero-width slice.
    always_comb begin
        bit_dec    = line_i ^ prev_q;
        stuff_slot = (STUFF_LEN != 0) && (ones_q == 4'(STUFF_LEN));
        shifted    = shift_q >> 1;
        shifted[WIDTH-1] = bit_dec;
    end

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        shift_d   = shift_q;
        data_d    = data_q;
        bit_cnt_d = bit_cnt_q;
        ones_d    = ones_q;
        valid_d   = valid_q & ~out_ready_i;
        ovf_d     = 1'b0;
        serr_d    = 1'b0;

        if (in_valid_i) begin
            if (sync_i) begin
                state_d   = RECV;
                prev_d    = line_i;
                shift_d   = '0;
                bit_cnt_d = '0;
                ones_d    = '0;
            end else if (state_q == RECV) begin
                prev_d = line_i;
                if (stuff_slot) begin
                    ones_d = '0;
                    if (bit_dec) begin
                        serr_d    = 1'b1;
                        state_d   = HUNT;
                        shift_d   = '0;
                        bit_cnt_d = '0;
                    end
                end else begin
                    if (STUFF_LEN != 0) begin
                        ones_d = bit_dec ? ones_q + 4'd1 : 4'd0;
                    end
                    shift_d = shifted;
                    if (bit_cnt_q == CW'(WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        // A word accepted in this same cycle frees the slot for the new one.
                        if (!valid_q || out_ready_i) begin
                            data_d  = shifted;
                            valid_d = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            state_q   <= HUNT;
            prev_q    <= 1'b0;
            shift_q   <= '0;
            data_q    <= '0;
            bit_cnt_q <= '0;
            ones_q    <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            serr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            bit_cnt_q <= bit_cnt_d;
            ones_q    <= ones_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            serr_q    <= serr_d;
        end
    end

    assign data_out_o    = data_q;
    assign out_valid_o   = valid_q;
    assign overflow_o    = ovf_q;
    assign stuff_error_o = serr_q;
    assign busy_o        = (state_q == RECV);

endmodule

// File: tb/tb_toggle_stream_decoder.sv
// tb/tb_toggle_stream_decoder.sv - self-checking bench for toggle_stream_decoder
module tb_toggle_stream_decoder;

    localparam int WIDTH     = 8;
    localparam int STUFF_LEN = 6;

    logic             clk = 1'b0;
    logic             clear, in_valid, line, sync, out_ready;
    logic [WIDTH-1:0] data_out;
    logic             out_valid, overflow, stuff_error, busy;

    toggle_stream_decoder #(.WIDTH(WIDTH), .STUFF_LEN(STUFF_LEN)) dut (
        .clk_i        (clk),
        .clear_i      (clear),
        .in_valid_i   (in_valid),
        .line_i       (line),
        .sync_i       (sync),
        .data_out_o   (data_out),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .overflow_o   (overflow),
        .stuff_error_o(stuff_error),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame state plus the bits of the current word held as a list.
    bit         m_recv, m_prev, m_valid, m_ovf, m_serr;
    bit         m_bits[$];
    int         m_ones;
    logic [WIDTH-1:0] m_out;

    task automatic model(input bit clr, input bit iv, input bit ln, input bit sy, input bit rdy);
        bit b;
        bit nv;
        logic [WIDTH-1:0] w;
        if (clr) begin
            m_recv = 0; m_prev = 0; m_valid = 0; m_ovf = 0; m_serr = 0;
            m_bits.delete(); m_ones = 0; m_out = '0;
            return;
        end
        m_ovf  = 0;
        m_serr = 0;
        nv     = m_valid && !rdy;
        if (iv && sy) begin
            m_recv = 1; m_prev = ln; m_bits.delete(); m_ones = 0;
        end else if (iv && m_recv) begin
            b      = ln ^ m_prev;
            m_prev = ln;
            if (STUFF_LEN > 0 && m_ones == STUFF_LEN) begin
                m_ones = 0;
                if (b) begin
                    m_serr = 1; m_recv = 0; m_bits.delete();
                end
            end else begin
                m_ones = b ? m_ones + 1 : 0;
                m_bits.push_back(b);
                if (m_bits.size() == WIDTH) begin
                    w = '0;
                    foreach (m_bits[i]) w[i] = m_bits[i];
                    m_bits.delete();
                    if (!m_valid || rdy) begin
                        m_out = w; nv = 1;
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
        end
        m_valid = nv;
    endtask

    task automatic cycle(input bit clr, input bit iv, input bit ln, input bit sy, input bit rdy);
        clear = clr; in_valid = iv; line = ln; sync = sy; out_ready = rdy;
        model(clr, iv, ln, sy, rdy);
        @(posedge clk);
        #1;
        check("data_out", 32'(data_out), 32'(m_out));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("stuff_error", 32'(stuff_error), 32'(m_serr));
        check("busy", 32'(busy), 32'(m_recv));
    endtask

    bit rdy_g = 0;
    bit gaps  = 0;

    task automatic send(input bit ln);
        if (gaps) begin
            int n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) cycle(0, 0, 1'($urandom), 1'($urandom), rdy_g);
        end
        cycle(0, 1, ln, 0, rdy_g);
    endtask

    task automatic send_seq(input logic [15:0] seq, input int n);
        logic [15:0] s;
        s = seq;
        for (int i = 0; i < n; i++) send(s[i]);
    endtask

    task automatic do_sync(input bit ln);
        cycle(0, 1, ln, 1, rdy_g);
    endtask

    // Line patterns, first sample in bit 0.
    localparam logic [15:0] SEQ_A5    = 16'b01100011;   // 1,1,0,0,0,1,1,0
    localparam logic [15:0] SEQ_STUFF = 16'b010010101;  // 1,0,1,0,1,0,0,1,0
    localparam logic [15:0] SEQ_VIOL  = 16'b1010101;    // 1,0,1,0,1,0,1

    initial begin
        bit tl;
        clear = 1; in_valid = 0; line = 0; sync = 0; out_ready = 0;
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 1, 1, 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(data_out), 0);

        // Samples before any sync are ignored.
        for (int i = 0; i < 5; i++) send(1'($urandom));
        check("hunt_busy", 32'(busy), 0);

        // Basic word
        rdy_g = 0;
        do_sync(0);
        check("basic_busy_sync", 32'(busy), 1);
        send_seq(SEQ_A5, 8);
        check("basic_data", 32'(data_out), 32'hA5);
        check("basic_valid", 32'(out_valid), 1);
        check("basic_busy", 32'(busy), 1);
        cycle(0, 0, 0, 0, 1);
        check("drain_valid", 32'(out_valid), 0);

        // Unstuffing
        do_sync(0);
        send_seq(SEQ_STUFF, 8);
        check("stuff_notyet", 32'(out_valid), 0);
        send(SEQ_STUFF[8]);
        check("stuff_data", 32'(data_out), 32'hFF);
        check("stuff_noerr", 32'(stuff_error), 0);
        cycle(0, 0, 0, 0, 1);

        // Stuffing violation
        do_sync(0);
        send_seq(SEQ_VIOL, 7);
        check("viol_err", 32'(stuff_error), 1);
        check("viol_busy", 32'(busy), 0);
        check("viol_valid", 32'(out_valid), 0);
        for (int i = 0; i < 10; i++) send(1'($urandom));
        check("viol_pulse", 32'(stuff_error), 0);
        check("viol_ignored", 32'(out_valid), 0);

        // Overflow and back-pressure
        rdy_g = 0;
        do_sync(0);
        send_seq(SEQ_A5, 8);
        send_seq(16'h0000, 8);
        check("ovf_pulse", 32'(overflow), 1);
        check("ovf_hold", 32'(data_out), 32'hA5);
        cycle(0, 0, 0, 0, 0);
        check("ovf_width", 32'(overflow), 0);
        cycle(0, 0, 0, 0, 1);
        check("ovf_drain", 32'(out_valid), 0);
        do_sync(0);
        send_seq(SEQ_A5, 8);
        send_seq(16'h0000, 7);
        rdy_g = 1;
        send(0);
        rdy_g = 0;
        check("accept_load", 32'(data_out), 32'h00);
        check("accept_noovf", 32'(overflow), 0);
        check("accept_valid", 32'(out_valid), 1);
        cycle(0, 0, 0, 0, 1);

        // Mid-frame clear
        do_sync(0);
        send_seq(SEQ_A5, 4);
        cycle(1, 1, 1, 0, 0);
        check("clr_busy", 32'(busy), 0);
        check("clr_data", 32'(data_out), 0);

        // Re-sync mid-word discards partial word
        do_sync(0);
        send_seq(SEQ_A5, 4);
        do_sync(0);
        send_seq(SEQ_A5, 7);
        check("resync_nopart", 32'(out_valid), 0);
        send(SEQ_A5[7]);
        check("resync_data", 32'(data_out), 32'hA5);
        cycle(0, 0, 0, 0, 1);

        // In_Valid gaps
        gaps = 1;
        do_sync(0);
        send_seq(SEQ_A5, 8);
        gaps = 0;
        check("gap_data", 32'(data_out), 32'hA5);
        check("gap_valid", 32'(out_valid), 1);
        cycle(0, 0, 0, 0, 1);

        // Randomized traffic biased toward runs of ones
        tl = 0;
        for (int i = 0; i < 4000; i++) begin
            bit clr_r, iv_r, sy_r, b_r;
            clr_r = ($urandom_range(0, 499) == 0);
            iv_r  = ($urandom_range(0, 3) != 0);
            sy_r  = ($urandom_range(0, 59) == 0);
            b_r   = ($urandom_range(0, 9) < 8);
            if (iv_r) tl = tl ^ b_r;
            cycle(clr_r, iv_r, tl, sy_r, 1'($urandom_range(0, 2) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
